im_loader: RTL and testbench

IM_LOADER -- requirements
Module: im_loader

---
 rtl/im_loader.sv | 92 +++++++++
 tb/tb_im_loader.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/im_loader.sv
// im_loader: instruction memory with a streaming program loader and a core read/write port.
// Optional per-word even parity is built when IM_LOADER_PARITY_EN is defined.
module im_loader #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] pc,
  input  logic          IM_enable,
  input  logic          IM_read,
  input  logic          IM_write,
  input  logic [31:0]   IM_in,
  output logic [31:0]   instruction,
  input  logic          load_start,
  input  logic [AW-1:0] load_count,
  input  logic          load_valid,
  input  logic [31:0]   load_data,
  output logic          load_ready,
  output logic          load_done,
  output logic          core_rst,
  output logic          parity_err
);
  typedef enum logic [1:0] {IDLE, LOAD, DONE, RUN} state_t;
  state_t state;
  logic [AW-1:0] cnt, last;
  logic [31:0] mem [DEPTH];
  logic xfer, core_rd, core_wr, we;
  logic [AW-1:0] waddr;
  logic [31:0] wdata;
  assign xfer    = load_valid & load_ready;
  assign core_rd = (state == RUN) & IM_enable & IM_read;
  assign core_wr = (state == RUN) & IM_enable & IM_write;
  assign we      = xfer | core_wr;
  assign waddr   = xfer ? cnt : pc;
  assign wdata   = xfer ? load_data : IM_in;
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      last       <= '0;
      load_ready <= 1'b0;
      load_done  <= 1'b0;
      core_rst   <= 1'b1;
    end else begin
      load_done <= 1'b0;
      case (state)
        IDLE, RUN: if (load_start) begin
          state      <= LOAD;
          cnt        <= '0;
          last       <= load_count;
          load_ready <= 1'b1;
          core_rst   <= 1'b1;
        end
        LOAD: if (xfer) begin
          if (cnt == last) begin
            state      <= DONE;
            load_ready <= 1'b0;
            load_done  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          state    <= RUN;
          core_rst <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
  // memory is deliberately left out of reset so a program survives rst
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end
  always_ff @(posedge clk) begin
    if (rst) instruction <= '0;
    else if (core_rd) instruction <= mem[pc];
  end
`ifdef IM_LOADER_PARITY_EN
  logic par [DEPTH];
  always_ff @(posedge clk) begin
    if (we) par[waddr] <= ^wdata;
  end
  always_ff @(posedge clk) begin
    if (rst) parity_err <= 1'b0;
    else if (core_rd) parity_err <= par[pc] ^ (^mem[pc]);
  end
`else
  assign parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_im_loader.sv
// tb_im_loader: randomized self-checking bench for im_loader against an array-based memory model.
module tb_im_loader;
  localparam int AW = 10;
  localparam int DEPTH = 1024;
  logic clk = 0, rst = 1;
  logic [AW-1:0] pc = '0;
  logic IM_enable = 0, IM_read = 0, IM_write = 0;
  logic [31:0] IM_in = '0;
  logic [31:0] instruction;
  logic load_start = 0;
  logic [AW-1:0] load_count = '0;
  logic load_valid = 0;
  logic [31:0] load_data = '0;
  logic load_ready, load_done, core_rst, parity_err;
  int n_cmp = 0, n_bad = 0;
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] ref_instr = '0;
  bit in_run = 0;

  im_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .pc(pc), .IM_enable(IM_enable), .IM_read(IM_read),
    .IM_write(IM_write), .IM_in(IM_in), .instruction(instruction),
    .load_start(load_start), .load_count(load_count), .load_valid(load_valid),
    .load_data(load_data), .load_ready(load_ready), .load_done(load_done),
    .core_rst(core_rst), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // core access; the model only reacts while the bench knows the core is running
  task automatic core_op(input bit en, input logic [AW-1:0] a, input bit r, input bit w,
                         input logic [31:0] d);
    pc = a; IM_enable = en; IM_read = r; IM_write = w; IM_in = d;
    step;
    IM_enable = 0; IM_read = 0; IM_write = 0;
    if (in_run && en) begin
      if (r) ref_instr = ref_mem[a];
      if (w) ref_mem[a] = d;
    end
    chk("instruction", instruction, ref_instr);
  endtask

  task automatic do_load(input int last);
    int i = 0, guard = 0, dones = 0;
    logic [31:0] d;
    load_start = 1; load_count = last[AW-1:0];
    step;
    load_start = 0; in_run = 0;
    chk("load_ready_in_load", {31'b0, load_ready}, 1);
    chk("core_rst_in_load", {31'b0, core_rst}, 1);
    while (i <= last && guard < 4 * DEPTH) begin
      d = $urandom;
      load_valid = ($urandom_range(0, 3) != 0);
      load_data = d;
      step;
      guard++;
      if (load_valid) begin
        ref_mem[i] = d;
        i++;
      end
      if (load_done) dones++;
    end
    for (int k = 0; k < 3; k++) begin
      load_valid = 1; load_data = $urandom;
      step;
      if (load_done) dones++;
    end
    load_valid = 0;
    chk("load_words", i, last + 1);
    chk("load_done_pulses", dones, 1);
    chk("core_rst_run", {31'b0, core_rst}, 0);
    chk("load_ready_run", {31'b0, load_ready}, 0);
    in_run = 1;
  endtask

  initial begin
    logic [31:0] w0, w1;
    step; step;
    chk("rst_instruction", instruction, 0);
    chk("rst_core_rst", {31'b0, core_rst}, 1);
    chk("rst_load_ready", {31'b0, load_ready}, 0);
    chk("rst_load_done", {31'b0, load_done}, 0);
    chk("rst_parity_err", {31'b0, parity_err}, 0);
    rst = 0;
    step;
    chk("idle_core_rst", {31'b0, core_rst}, 1);

    // three-word load with a gap on load_valid
    load_start = 1; load_count = 2;
    step;
    load_start = 0;
    chk("l3_ready", {31'b0, load_ready}, 1);
    load_valid = 1; load_data = 32'h11111111; step; ref_mem[0] = 32'h11111111;
    load_valid = 0; step;
    chk("l3_gap_ready", {31'b0, load_ready}, 1);
    chk("l3_gap_done", {31'b0, load_done}, 0);
    load_valid = 1; load_data = 32'h22222222; step; ref_mem[1] = 32'h22222222;
    load_data = 32'h33333333; step; ref_mem[2] = 32'h33333333;
    load_valid = 0;
    chk("l3_done", {31'b0, load_done}, 1);
    chk("l3_done_core_rst", {31'b0, core_rst}, 1);
    chk("l3_done_ready", {31'b0, load_ready}, 0);
    step;
    chk("l3_done_end", {31'b0, load_done}, 0);
    chk("l3_run_core_rst", {31'b0, core_rst}, 0);
    in_run = 1;
    core_op(1, 1, 1, 0, 0);
    chk("l3_read_pc1", instruction, 32'h22222222);

    // read-before-write at the same address
    core_op(1, 5, 0, 1, 32'hA5A5A5A5);
    core_op(1, 5, 1, 1, 32'hDEADBEEF);
    chk("rbw_old", instruction, 32'hA5A5A5A5);
    core_op(1, 5, 1, 0, 0);
    chk("rbw_new", instruction, 32'hDEADBEEF);

    // reset in the middle of a load keeps already written words
    w0 = $urandom; w1 = $urandom;
    load_start = 1; load_count = 3; step; load_start = 0; in_run = 0;
    load_valid = 1; load_data = w0; step; ref_mem[0] = w0;
    load_data = w1; step; ref_mem[1] = w1;
    load_valid = 0; rst = 1; step; rst = 0; ref_instr = '0;
    chk("abort_ready", {31'b0, load_ready}, 0);
    chk("abort_core_rst", {31'b0, core_rst}, 1);
    chk("abort_instr", instruction, 0);
    core_op(1, 1, 1, 1, 32'hBADBAD00);
    step;
    chk("abort_idle_core_rst", {31'b0, core_rst}, 1);
    chk("abort_idle_ready", {31'b0, load_ready}, 0);
    do_load(0);
    core_op(1, 1, 1, 0, 0);
    chk("abort_word1", instruction, w1);

    // full-depth load
    do_load(DEPTH - 1);
    core_op(1, 0, 1, 0, 0);
    core_op(1, AW'(DEPTH - 1), 1, 0, 0);

    // randomized core traffic over a small window to force address collisions
    for (int k = 0; k < 300; k++)
      core_op($urandom_range(0, 4) != 0, AW'($urandom_range(0, 15)),
              $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0, $urandom);
    for (int k = 0; k < 16; k++) core_op(1, AW'(k), 1, 0, 0);

    // reload from RUN and make sure ignored requests during LOAD leave memory intact
    load_start = 1; load_count = 1; step; load_start = 0; in_run = 0;
    chk("reload_core_rst", {31'b0, core_rst}, 1);
    core_op(1, 20, 1, 1, 32'h0BAD0BAD);
    load_valid = 1; load_data = 32'h01234567; step; ref_mem[0] = 32'h01234567;
    load_data = 32'h89ABCDEF; step; ref_mem[1] = 32'h89ABCDEF;
    load_valid = 0;
    chk("reload_done", {31'b0, load_done}, 1);
    step; in_run = 1;
    core_op(1, 20, 1, 0, 0);
    core_op(1, 1, 1, 0, 0);

`ifdef IM_LOADER_PARITY_EN
    core_op(1, 2, 1, 0, 0);
    chk("parity_clean", {31'b0, parity_err}, 0);
    dut.par[2] = ~dut.par[2];
    core_op(1, 2, 1, 0, 0);
    chk("parity_flip", {31'b0, parity_err}, 1);
`else
    chk("parity_off", {31'b0, parity_err}, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
